// File: rtl/univ_reg_pkg.sv
// Shared definitions for the universal flip-flop register: operation codes
// and small helpers used by both the RTL and its bench.
package univ_reg_pkg;

    localparam logic [2:0] MODE_HOLD   = 3'b000;
    localparam logic [2:0] MODE_LOAD   = 3'b001;
    localparam logic [2:0] MODE_TOGGLE = 3'b010;
    localparam logic [2:0] MODE_SHL    = 3'b011;
    localparam logic [2:0] MODE_SHR    = 3'b100;
    localparam logic [2:0] MODE_UP     = 3'b101;
    localparam logic [2:0] MODE_DOWN   = 3'b110;
    localparam logic [2:0] MODE_RSVD   = 3'b111;

    // Right shifts expose the low bit; every other mode exposes the high bit.
    function automatic logic sout_from_lsb(input logic [2:0] mode);
        return (mode == MODE_SHR);
    endfunction

endpackage

// File: rtl/univ_ff_reg.sv
// Universal register: hold/load/toggle/shift/count with a terminal-count flag.
// q and tc are the only state; qbar and sout are decoded from q.
module univ_ff_reg
    import univ_reg_pkg::*;
#(
    parameter int              WIDTH      = 8,
    parameter logic [WIDTH-1:0] RST_VAL   = {WIDTH{1'b0}},
    parameter int              COUNT_WRAP = 1
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             en,
    input  logic [2:0]       mode,
    input  logic [WIDTH-1:0] d,
    input  logic             sin,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] qbar,
    output logic             sout,
    output logic             tc
);

    localparam logic [WIDTH-1:0] ALL_ONES = {WIDTH{1'b1}};
    localparam logic [WIDTH-1:0] ALL_ZERO = {WIDTH{1'b0}};
    localparam logic [WIDTH-1:0] ONE      = {{(WIDTH-1){1'b0}}, 1'b1};

    logic [WIDTH-1:0] q_r;
    logic             tc_r;
    logic [WIDTH-1:0] q_nxt_s;
    logic             tc_nxt_s;

    // Next-state and terminal-count decode for the selected operation.
    always_comb begin
        q_nxt_s  = q_r;
        tc_nxt_s = 1'b0;
        if (en) begin
            case (mode)
                MODE_HOLD:   q_nxt_s = q_r;
                MODE_LOAD:   q_nxt_s = d;
                MODE_TOGGLE: q_nxt_s = q_r ^ d;
                MODE_SHL:    q_nxt_s = {q_r[WIDTH-2:0], sin};
                MODE_SHR:    q_nxt_s = {sin, q_r[WIDTH-1:1]};
                MODE_UP: begin
                    if (q_r == ALL_ONES) begin
                        tc_nxt_s = 1'b1;
                        q_nxt_s  = (COUNT_WRAP != 0) ? ALL_ZERO : ALL_ONES;
                    end else begin
                        q_nxt_s  = q_r + ONE;
                    end
                end
                MODE_DOWN: begin
                    if (q_r == ALL_ZERO) begin
                        tc_nxt_s = 1'b1;
                        q_nxt_s  = (COUNT_WRAP != 0) ? ALL_ONES : ALL_ZERO;
                    end else begin
                        q_nxt_s  = q_r - ONE;
                    end
                end
                default:     q_nxt_s = q_r;
            endcase
        end else begin
            q_nxt_s  = q_r;
            tc_nxt_s = 1'b0;
        end
    end

    // State register; reset is sampled on the edge and overrides any operation.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            q_r  <= RST_VAL;
            tc_r <= 1'b0;
        end else begin
            q_r  <= q_nxt_s;
            tc_r <= tc_nxt_s;
        end
    end

    assign q    = q_r;
    assign qbar = ~q_r;
    assign sout = sout_from_lsb(mode) ? q_r[0] : q_r[WIDTH-1];
    assign tc   = tc_r;

endmodule

// File: tb/tb_univ_ff_reg.sv
// Scoreboard bench: wrapping and saturating instances share one stimulus
// stream; each driven cycle queues the expected post-edge state of both.
module tb_univ_ff_reg;
    import univ_reg_pkg::*;

    logic       clk = 1'b0;
    logic       rstn = 1'b0;
    logic       en = 1'b0;
    logic [2:0] mode = MODE_HOLD;
    logic [7:0] d = 8'h00;
    logic       sin = 1'b0;

    logic [7:0] q_w, qbar_w, q_s, qbar_s;
    logic       sout_w, tc_w, sout_s, tc_s;

    typedef struct {
        logic [7:0] qw;
        logic       tw;
        logic [7:0] qs;
        logic       ts;
        logic [2:0] mode;
    } exp_t;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_bad = 0;
    bit   stim_done = 1'b0;

    always #5 clk = ~clk;

    univ_ff_reg #(.WIDTH(8), .RST_VAL(8'h5A), .COUNT_WRAP(1)) dut_w (
        .clk(clk), .rstn(rstn), .en(en), .mode(mode), .d(d), .sin(sin),
        .q(q_w), .qbar(qbar_w), .sout(sout_w), .tc(tc_w)
    );

    univ_ff_reg #(.WIDTH(8), .RST_VAL(8'h5A), .COUNT_WRAP(0)) dut_s (
        .clk(clk), .rstn(rstn), .en(en), .mode(mode), .d(d), .sin(sin),
        .q(q_s), .qbar(qbar_s), .sout(sout_s), .tc(tc_s)
    );

    task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Drive one cycle of inputs (called at a falling edge) and queue the result.
    task automatic step(input logic r, input logic e, input logic [2:0] m,
                        input logic [7:0] dd, input logic s,
                        input logic [7:0] qw, input logic tw,
                        input logic [7:0] qs, input logic ts);
        exp_t x;
        rstn = r; en = e; mode = m; d = dd; sin = s;
        x.qw = qw; x.tw = tw; x.qs = qs; x.ts = ts; x.mode = m;
        sb.push_back(x);
        @(negedge clk);
    endtask

    // Monitor: after every rising edge, compare against the oldest expectation.
    initial begin
        exp_t x;
        forever begin
            @(posedge clk);
            #1;
            if (sb.size() > 0) begin
                x = sb.pop_front();
                chk("q_wrap",    q_w,    x.qw);
                chk("qbar_wrap", qbar_w, ~x.qw);
                chk("tc_wrap",   {7'd0, tc_w}, {7'd0, x.tw});
                chk("sout_wrap", {7'd0, sout_w},
                    {7'd0, (x.mode == MODE_SHR) ? x.qw[0] : x.qw[7]});
                chk("q_sat",     q_s,    x.qs);
                chk("qbar_sat",  qbar_s, ~x.qs);
                chk("tc_sat",    {7'd0, tc_s}, {7'd0, x.ts});
                chk("sout_sat",  {7'd0, sout_s},
                    {7'd0, (x.mode == MODE_SHR) ? x.qs[0] : x.qs[7]});
            end
        end
    end

    initial begin
        @(negedge clk);
        //   rstn en  mode         d      sin   q_wrap tc    q_sat  tc
        step(1'b0, 1'b1, MODE_UP,     8'h00, 1'b0, 8'h5A, 1'b0, 8'h5A, 1'b0);
        step(1'b1, 1'b1, MODE_LOAD,   8'h0F, 1'b0, 8'h0F, 1'b0, 8'h0F, 1'b0);
        step(1'b1, 1'b1, MODE_TOGGLE, 8'hFF, 1'b0, 8'hF0, 1'b0, 8'hF0, 1'b0);
        step(1'b1, 1'b0, MODE_UP,     8'h33, 1'b1, 8'hF0, 1'b0, 8'hF0, 1'b0);
        step(1'b1, 1'b0, MODE_LOAD,   8'h33, 1'b1, 8'hF0, 1'b0, 8'hF0, 1'b0);
        step(1'b1, 1'b0, MODE_SHL,    8'h33, 1'b1, 8'hF0, 1'b0, 8'hF0, 1'b0);
        step(1'b1, 1'b1, MODE_LOAD,   8'h81, 1'b0, 8'h81, 1'b0, 8'h81, 1'b0);
        step(1'b1, 1'b1, MODE_SHL,    8'h00, 1'b0, 8'h02, 1'b0, 8'h02, 1'b0);
        step(1'b1, 1'b1, MODE_SHR,    8'h00, 1'b1, 8'h81, 1'b0, 8'h81, 1'b0);
        step(1'b1, 1'b1, MODE_LOAD,   8'hFE, 1'b0, 8'hFE, 1'b0, 8'hFE, 1'b0);
        step(1'b1, 1'b1, MODE_UP,     8'h00, 1'b0, 8'hFF, 1'b0, 8'hFF, 1'b0);
        step(1'b1, 1'b1, MODE_UP,     8'h00, 1'b0, 8'h00, 1'b1, 8'hFF, 1'b1);
        step(1'b1, 1'b1, MODE_UP,     8'h00, 1'b0, 8'h01, 1'b0, 8'hFF, 1'b1);
        step(1'b1, 1'b1, MODE_DOWN,   8'h00, 1'b0, 8'h00, 1'b0, 8'hFE, 1'b0);
        step(1'b1, 1'b1, MODE_DOWN,   8'h00, 1'b0, 8'hFF, 1'b1, 8'hFD, 1'b0);
        step(1'b1, 1'b1, MODE_LOAD,   8'h01, 1'b0, 8'h01, 1'b0, 8'h01, 1'b0);
        step(1'b1, 1'b1, MODE_DOWN,   8'h00, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0);
        step(1'b1, 1'b1, MODE_DOWN,   8'h00, 1'b0, 8'hFF, 1'b1, 8'h00, 1'b1);
        step(1'b1, 1'b1, MODE_DOWN,   8'h00, 1'b0, 8'hFE, 1'b0, 8'h00, 1'b1);
        step(1'b1, 1'b1, MODE_RSVD,   8'hAA, 1'b1, 8'hFE, 1'b0, 8'h00, 1'b0);
        step(1'b1, 1'b1, MODE_HOLD,   8'hAA, 1'b1, 8'hFE, 1'b0, 8'h00, 1'b0);
        step(1'b1, 1'b0, MODE_DOWN,   8'h00, 1'b0, 8'hFE, 1'b0, 8'h00, 1'b0);
        step(1'b1, 1'b1, MODE_LOAD,   8'h10, 1'b0, 8'h10, 1'b0, 8'h10, 1'b0);
        step(1'b1, 1'b1, MODE_UP,     8'h00, 1'b0, 8'h11, 1'b0, 8'h11, 1'b0);
        step(1'b1, 1'b1, MODE_UP,     8'h00, 1'b0, 8'h12, 1'b0, 8'h12, 1'b0);
        // rstn falling between edges must not disturb q until the next edge
        rstn = 1'b0;
        #1;
        chk("q_wrap_no_async_rst", q_w, 8'h12);
        chk("q_sat_no_async_rst",  q_s, 8'h12);
        step(1'b0, 1'b1, MODE_UP,     8'h00, 1'b0, 8'h5A, 1'b0, 8'h5A, 1'b0);
        step(1'b1, 1'b1, MODE_UP,     8'h00, 1'b0, 8'h5B, 1'b0, 8'h5B, 1'b0);
        en = 1'b0;
        for (int i = 0; i < 5 && sb.size() > 0; i++) @(negedge clk);
        if (sb.size() > 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL drain: %0d expectations left, required 0", sb.size());
        end
        stim_done = 1'b1;
    end

    initial begin
        wait (stim_done == 1'b1 || $time > 2000);
        if (stim_done == 1'b0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL timeout: stim_done 0, required 1");
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
